// File: rtl/pick_best_mode.sv
// pick_best_mode: sequences an external reconstruct/score engine over the
// enabled candidate modes, scores each one by rate-distortion cost and keeps
// the cheapest. Wide payloads stay outside; store_en tells the owner of those
// buffers when the current candidate has become the new best.
module pick_best_mode #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 4,
    parameter int COST_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_MODES-1:0]        mode_mask,
    input  logic [COST_W*NUM_MODES-1:0] fixed_cost,
    input  logic [31:0]                 lambda_sel,
    input  logic [31:0]                 lambda_final,
    input  logic [31:0]                 tlambda,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [MODE_W-1:0]           req_mode,
    input  logic                        rsp_valid,
    input  logic [31:0]                 rsp_sse,
    input  logic [31:0]                 rsp_disto,
    input  logic [31:0]                 rsp_rate,
    input  logic [31:0]                 rsp_nz,
    output logic                        store_en,
    output logic                        busy,
    output logic                        done,
    output logic                        none_valid,
    output logic [MODE_W-1:0]           best_mode,
    output logic [63:0]                 best_score,
    output logic [31:0]                 best_sse,
    output logic [31:0]                 best_disto,
    output logic [31:0]                 best_rate,
    output logic [31:0]                 best_nz
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_SCORE, S_COMP, S_FINAL, S_DONE
    } state_t;

    // Engine result captured for the mode currently being evaluated.
    typedef struct packed {
        logic [31:0] sse;
        logic [31:0] disto;
        logic [31:0] rate;
        logic [31:0] nz;
    } rsp_t;

    state_t               state, state_nxt;
    logic [NUM_MODES-1:0] pending;    // enabled modes not yet requested
    logic                 have_best;  // a candidate has been compared this search
    rsp_t                 cand;
    logic [63:0]          score;      // search-lambda score of cand
    logic [63:0]          run_best;   // search-lambda score of the current best
    logic                 better;

    // Highest set bit of a mode set; modes are walked from the top down.
    function automatic logic [MODE_W-1:0] top_mode(input logic [NUM_MODES-1:0] m);
        top_mode = '0;
        for (int i = 0; i < NUM_MODES; i++)
            if (m[i]) top_mode = MODE_W'(i);
    endfunction

    // Header cost of a mode, zero-extended to the 64-bit score domain.
    function automatic logic [63:0] hdr_cost(input logic [COST_W*NUM_MODES-1:0] tab,
                                             input logic [MODE_W-1:0] mode);
        hdr_cost = '0;
        for (int i = 0; i < NUM_MODES; i++)
            if (mode == MODE_W'(i)) hdr_cost = 64'(tab[COST_W*i +: COST_W]);
    endfunction

    // ((R<<10)+H)*lambda + 256*(D + ((SD*tlambda+128)>>8)), all modulo 2^64.
    function automatic logic [63:0] rd_score(input logic [31:0] rate,
                                             input logic [31:0] disto,
                                             input logic [31:0] sse,
                                             input logic [63:0] h,
                                             input logic [31:0] lambda,
                                             input logic [31:0] tl);
        logic [63:0] spec;
        spec     = (64'(disto) * 64'(tl) + 64'd128) >> 8;
        rd_score = ((64'(rate) << 10) + h) * 64'(lambda) + ((64'(sse) + spec) << 8);
    endfunction

    // Ties favour the later-evaluated candidate, i.e. the lower mode index.
    assign better = !have_best || (score <= run_best);

    // Handshake/pulse outputs are killed in the same cycle by abort or reset.
    assign req_valid = (state == S_ISSUE) && !abort && !rst;
    assign store_en  = (state == S_COMP) && better && !abort && !rst;
    assign done      = (state == S_DONE) && !abort && !rst;
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition. An empty mask
    // still passes through FINAL (which then leaves the result untouched)
    // so done appears two cycles after start.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (|mode_mask) ? S_ISSUE : S_FINAL;
            S_ISSUE: if (req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (rsp_valid) state_nxt = S_SCORE;
            S_SCORE: state_nxt = S_COMP;
            S_COMP:  state_nxt = (|pending) ? S_ISSUE : S_FINAL;
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Datapath: mode bookkeeping, scoring, best tracking and final result.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            have_best  <= 1'b0;
            cand       <= '0;
            score      <= '0;
            run_best   <= '1;
            req_mode   <= '0;
            none_valid <= 1'b0;
            best_mode  <= '0;
            best_score <= '1;
            best_sse   <= '0;
            best_disto <= '0;
            best_rate  <= '0;
            best_nz    <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE: if (start) begin
                    pending    <= mode_mask;
                    have_best  <= 1'b0;
                    none_valid <= ~|mode_mask;
                    req_mode   <= top_mode(mode_mask);
                    if (~|mode_mask) begin
                        best_mode  <= '0;
                        best_score <= '1;
                        best_sse   <= '0;
                        best_disto <= '0;
                        best_rate  <= '0;
                        best_nz    <= '0;
                    end
                end
                S_ISSUE: if (req_ready)
                    pending <= pending & ~(NUM_MODES'(1) << req_mode);
                S_WAIT: if (rsp_valid) begin
                    cand.sse   <= rsp_sse;
                    cand.disto <= rsp_disto;
                    cand.rate  <= rsp_rate;
                    cand.nz    <= rsp_nz;
                end
                S_SCORE:
                    score <= rd_score(cand.rate, cand.disto, cand.sse,
                                      hdr_cost(fixed_cost, req_mode), lambda_sel, tlambda);
                S_COMP: begin
                    if (better) begin
                        have_best  <= 1'b1;
                        run_best   <= score;
                        best_mode  <= req_mode;
                        best_sse   <= cand.sse;
                        best_disto <= cand.disto;
                        best_rate  <= cand.rate;
                        best_nz    <= cand.nz;
                    end
                    if (|pending) req_mode <= top_mode(pending);
                end
                S_FINAL: if (!none_valid)
                    best_score <= rd_score(best_rate, best_disto, best_sse,
                                           hdr_cost(fixed_cost, best_mode), lambda_final, tlambda);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pick_best_mode.sv
// Scoreboard bench for pick_best_mode: stimulus pushes the expected request,
// store and done events; a monitor pops and compares them as the DUT emits.
module tb_pick_best_mode;
    localparam int NM = 4;
    localparam int MW = 4;
    localparam int CW = 16;
    localparam int EV_REQ = 0, EV_STORE = 1, EV_DONE = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [NM-1:0]    mode_mask = '0;
    logic [CW*NM-1:0] fixed_cost = '0;
    logic [31:0] lambda_sel = '0, lambda_final = '0, tlambda = '0;
    logic req_valid, req_ready = 1'b1;
    logic [MW-1:0] req_mode;
    logic rsp_valid, eng_vld = 1'b0, spur_vld = 1'b0;
    logic [31:0] rsp_sse = '0, rsp_disto = '0, rsp_rate = '0, rsp_nz = '0;
    logic store_en, busy, done, none_valid;
    logic [MW-1:0] best_mode;
    logic [63:0] best_score;
    logic [31:0] best_sse, best_disto, best_rate, best_nz;

    assign rsp_valid = eng_vld | spur_vld;

    pick_best_mode #(.NUM_MODES(NM), .MODE_W(MW), .COST_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode_mask(mode_mask), .fixed_cost(fixed_cost),
        .lambda_sel(lambda_sel), .lambda_final(lambda_final), .tlambda(tlambda),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_sse(rsp_sse), .rsp_disto(rsp_disto),
        .rsp_rate(rsp_rate), .rsp_nz(rsp_nz),
        .store_en(store_en), .busy(busy), .done(done), .none_valid(none_valid),
        .best_mode(best_mode), .best_score(best_score), .best_sse(best_sse),
        .best_disto(best_disto), .best_rate(best_rate), .best_nz(best_nz)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rsp_delay = 0;
    logic [31:0] sse_tab [16], disto_tab [16], rate_tab [16], nz_tab [16];

    typedef struct {
        int          kind;
        logic [MW-1:0] mode;
        logic [63:0] score;
        logic        none;
        logic [31:0] sse;
        logic [31:0] nz;
    } ev_t;
    ev_t q[$];

    task automatic push(input int k, input logic [MW-1:0] m, input logic [63:0] s,
                        input logic n, input logic [31:0] sse, input logic [31:0] nz);
        ev_t e;
        e.kind = k; e.mode = m; e.score = s; e.none = n; e.sse = sse; e.nz = nz;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int k, input logic [MW-1:0] m, input logic [63:0] s,
                           input logic n, input logic [31:0] sse, input logic [31:0] nz);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d mode=%0d with nothing expected", k, m);
            return;
        end
        e = q.pop_front();
        if (e.kind != k || e.mode !== m ||
            (k == EV_DONE && (e.score !== s || e.none !== n || e.sse !== sse || e.nz !== nz))) begin
            errors++;
            $display("FAIL event: got kind=%0d mode=%0d score=%0d none=%0b sse=%0d nz=%0d expected kind=%0d mode=%0d score=%0d none=%0b sse=%0d nz=%0d",
                     k, m, s, n, sse, nz, e.kind, e.mode, e.score, e.none, e.sse, e.nz);
        end
    endtask

    // Monitor: every handshake, store pulse and done pulse is matched in order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_valid && req_ready) observe(EV_REQ, req_mode, '0, 1'b0, '0, '0);
                if (store_en) observe(EV_STORE, req_mode, '0, 1'b0, '0, '0);
                if (done) observe(EV_DONE, best_mode, best_score, none_valid, best_sse, best_nz);
            end
        end
    end

    // Engine model: answers each accepted request after rsp_delay extra cycles.
    initial begin : engine
        logic [MW-1:0] m;
        forever begin
            @(negedge clk);
            if (!rst && req_valid && req_ready) begin
                m = req_mode;
                @(posedge clk);
                repeat (rsp_delay) @(posedge clk);
                #1;
                eng_vld = 1'b1;
                rsp_sse = sse_tab[m]; rsp_disto = disto_tab[m];
                rsp_rate = rate_tab[m]; rsp_nz = nz_tab[m];
                @(posedge clk);
                #1 eng_vld = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        #1;
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_queue_drained"}, 64'(q.size()), 64'd0);
    endtask

    // Costs {919,872,919,663} for modes 3..0, sse=100 everywhere.
    task automatic setup1();
        mode_mask = 4'hF;
        fixed_cost = {16'd919, 16'd872, 16'd919, 16'd663};
        lambda_sel = 1; lambda_final = 2; tlambda = 0;
        for (int m = 0; m < 16; m++) begin
            sse_tab[m] = 100; disto_tab[m] = 0; rate_tab[m] = 0; nz_tab[m] = 32'(m + 1);
        end
    endtask

    // Search scores 26519, 26472, 26519, 26263; final 2*663+25600 = 26926.
    task automatic expect1();
        push(EV_REQ, 3, 0, 0, 0, 0); push(EV_STORE, 3, 0, 0, 0, 0);
        push(EV_REQ, 2, 0, 0, 0, 0); push(EV_STORE, 2, 0, 0, 0, 0);
        push(EV_REQ, 1, 0, 0, 0, 0);
        push(EV_REQ, 0, 0, 0, 0, 0); push(EV_STORE, 0, 0, 0, 0, 0);
        push(EV_DONE, 0, 64'd26926, 0, 100, 1);
    endtask

    initial begin
        bit found;
        for (int m = 0; m < 16; m++) begin
            sse_tab[m] = 0; disto_tab[m] = 0; rate_tab[m] = 0; nz_tab[m] = 0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_best_score", best_score, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_outputs", {busy, done, req_valid, store_en, none_valid, best_mode},
            64'd0);
        chk("rst_best_fields", {best_sse, best_nz}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: basic four-mode search
        setup1(); expect1();
        pulse_start(); wait_done("t1");

        // 2: mode 0 gets SD=10, tlambda=30 -> +1 term, 26519 loses to mode 2.
        // Mode 2 has SD=0, so final = 2*872 + 256*(100+0) = 27344.
        setup1(); disto_tab[0] = 10; tlambda = 30;
        push(EV_REQ, 3, 0, 0, 0, 0); push(EV_STORE, 3, 0, 0, 0, 0);
        push(EV_REQ, 2, 0, 0, 0, 0); push(EV_STORE, 2, 0, 0, 0, 0);
        push(EV_REQ, 1, 0, 0, 0, 0); push(EV_REQ, 0, 0, 0, 0, 0);
        push(EV_DONE, 2, 64'd27344, 0, 100, 3);
        pulse_start(); wait_done("t2");

        // 3: ties everywhere -> every mode stores, lowest index wins
        setup1(); fixed_cost = {4{16'd500}};
        for (int m = 0; m < 16; m++) nz_tab[m] = 7;
        for (int m = 3; m >= 0; m--) begin
            push(EV_REQ, MW'(m), 0, 0, 0, 0); push(EV_STORE, MW'(m), 0, 0, 0, 0);
        end
        push(EV_DONE, 0, 64'd26600, 0, 100, 7);
        pulse_start(); wait_done("t3");

        // 4a: sparse mask 0101
        setup1(); mode_mask = 4'b0101;
        push(EV_REQ, 2, 0, 0, 0, 0); push(EV_STORE, 2, 0, 0, 0, 0);
        push(EV_REQ, 0, 0, 0, 0, 0); push(EV_STORE, 0, 0, 0, 0, 0);
        push(EV_DONE, 0, 64'd26926, 0, 100, 1);
        pulse_start(); wait_done("t4a");

        // 4b: empty mask -> done two cycles after start, no-candidate result
        mode_mask = '0;
        push(EV_DONE, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        pulse_start();
        @(negedge clk); chk("t4b_done_early", 64'(done), 64'd0);
        @(negedge clk); chk("t4b_done_on_time", 64'(done), 64'd1);
        #1 chk("t4b_queue_drained", 64'(q.size()), 64'd0);

        // 5: backpressure plus spurious response while in ISSUE
        setup1(); req_ready = 1'b0; expect1();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) spur_vld = 1'b1;
            if (i == 2) spur_vld = 1'b0;
            @(negedge clk);
            chk("t5_req_hold", {req_valid, req_mode}, {1'b1, 4'd3});
        end
        @(posedge clk); #1 req_ready = 1'b1;
        wait_done("t5");

        // 6a: abort while waiting on the second mode's response
        setup1(); rsp_delay = 3;
        push(EV_REQ, 3, 0, 0, 0, 0); push(EV_STORE, 3, 0, 0, 0, 0);
        push(EV_REQ, 2, 0, 0, 0, 0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (req_valid && req_ready && req_mode == 2) found = 1'b1;
        end
        chk("t6_second_req_seen", 64'(found), 64'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t6_idle_after_abort", {busy, req_valid}, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) found = 1'b1;
        end
        chk("t6_quiet_after_abort", 64'(found), 64'd0);
        rsp_delay = 0;

        // 6b: fresh search after abort completes normally
        expect1();
        pulse_start(); wait_done("t6b");

        // 6c: reset mid-search restores reset values
        push(EV_REQ, 3, 0, 0, 0, 0); push(EV_STORE, 3, 0, 0, 0, 0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (store_en) found = 1'b1;
        end
        chk("t6c_store_seen", 64'(found), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6c_rst_best_score", best_score, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6c_rst_outputs", {busy, done, req_valid, store_en, none_valid, best_mode}, 64'd0);
        chk("t6c_rst_best_fields", {best_sse, best_nz}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
